seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Downstream consumer of the digit-scan select counter. Captures a binary value, converts it to BCD
//  (sequential double-dabble), and drives a multiplexed common-anode 7-segment display. Only the
//  digit chosen by the upstream select is driven. A blanking gap after every select change
//  prevents ghosting.
// PARAMETERS
//  NUM_DIGITS  3   display digits; digit 0 = least significant, on an[0]
//  BIN_W       10  width of input binary value
//  BLANK_CYC   4   extra anode-off cycles after a select change (0 allowed)
// PORTS
//  clk         in   1           system clock
//  rstn        in   1           asynchronous reset, active-low
//  sel         in   2           digit index from scan counter
//  value       in   BIN_W       binary value to display
//  dp_mask     in   NUM_DIGITS  decimal point enables, bit i = digit i, 1 = lit
//  value_valid in   1           value/dp_mask offered
//  value_ready out  1           converter idle, will accept
//  an          out  NUM_DIGITS  anodes, active-low, one-hot-low or all 1
//  seg         out  7           segments {g,f,e,d,c,b,a}, active-low
//  dp          out  1           decimal point, active-low
// BEHAVIOUR
//  Reset: an=all 1, seg=7'h7F, dp=1, value_ready=1, FSM=IDLE, shadow digits=0, ovf=0, sel_q=0,
//   blank_cnt=0. All outputs are registered.
//  Converter FSM: IDLE -> ADD -> SHIFT, with ADD/SHIFT repeated BIN_W times -> DONE -> IDLE.
//   - value_ready=1 only in IDLE. Accept when valid&&ready, which captures value and dp_mask.
//   - ovf = (value >= 10**NUM_DIGITS), evaluated at capture.
//   - ADD: each BCD nibble >=5 gets +3. SHIFT: {bcd,bin} <<= 1.
//   - DONE: commit BCD digits, dp_mask and ovf to the shadow registers atomically.
//   - Shadow is visible 2*BIN_W+1 edges after the accept edge (21 at default).
//   - valid while busy is ignored; upstream holds value until ready.
//  Scan path, evaluated each edge in this priority order:
//   - sel!=sel_q: sel_q<=sel, blank_cnt<=BLANK_CYC, an<=all 1, seg<=7'h7F, dp<=1.
//   - else blank_cnt!=0: blank_cnt--, outputs stay off.
//   - else if sel_q<NUM_DIGITS: an[sel_q]<=0, others 1; seg<=decode(shadow[sel_q]);
//     dp<=~dp_shadow[sel_q].
//   - else (sel_q>=NUM_DIGITS): an=all 1, seg=7'h7F, dp=1.
//   - After a select change, anodes are off for exactly BLANK_CYC+1 cycles. sel must be held
//     >= BLANK_CYC+2 cycles for the digit to be lit.
//  Decode: 0..9 standard patterns (0=7'b1000000, 4=7'b0011001, 7=7'b1111000). ovf=1 -> every
//   digit shows a dash, 7'b0111111.
//  Commit while a digit is lit: seg/dp update on the next edge with no blanking.
//  Reset mid-conversion: FSM aborts to IDLE, shadow cleared, display blanked immediately.
// CONFIGURATION
//  SEG7_LZB_EN defined: leading-zero blanking. Digits above the most significant nonzero digit
//   drive seg=7'h7F and dp from dp_shadow; their anode is still driven. Digit 0 is never
//   blanked. No effect when ovf=1.
//  SEG7_LZB_EN undefined: every digit shows its value, including leading zeros.
// TESTING
//  1 Reset assert/release -> an=3'b111, seg=7'h7F, dp=1, value_ready=1. sel=3 held -> an stays 3'b111.
//  2 value=437, sel held 2 -> ready low 21 cycles, then an=3'b011, seg=7'b0011001.
//  3 sel 0->1, BLANK_CYC=4 -> an=3'b111 for 5 cycles, then an=3'b101 with digit-1 pattern.
//  4 value=1000 -> ovf; sel 0/1/2 each give seg=7'b0111111. dp_mask=3'b010, sel=1 -> dp=0.
//  5 value=7, sel=2 -> LZB_EN: seg=7'h7F, an=3'b011. Without it: seg=7'b1000000. sel=0 -> 7'b1111000.
//  6 rstn low at cycle 10 of a conversion -> reset values; then a new value=5 is accepted, shows '5'.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a scanned common-anode 7-segment display.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 3,
    parameter int BIN_W      = 10,
    parameter int BLANK_CYC  = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [1:0]            sel,
    input  logic [BIN_W-1:0]      value,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    input  logic                  value_valid,
    output logic                  value_ready,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int          BCD_W     = 4 * NUM_DIGITS;
    localparam int          CNT_W     = $clog2(BIN_W + 1);
    localparam int          BLK_W     = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
    localparam logic [31:0] OVF_LIMIT = 32'(10 ** NUM_DIGITS);
    localparam logic [6:0]  SEG_OFF   = 7'h7F;
    localparam logic [6:0]  SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_SHIFT, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [BIN_W-1:0]        bin_q, bin_d;
    logic [BCD_W-1:0]        bcd_q, bcd_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   dpm_q, dpm_d;
    logic                    ovf_q, ovf_d;
    logic                    ready_q, ready_d;

    // Shadow registers seen by the scan path; only updated atomically in S_DONE.
    logic [BCD_W-1:0]        digit_q, digit_d;
    logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
    logic                    ovf_sh_q, ovf_sh_d;

    logic [1:0]              sel_q, sel_d;
    logic [BLK_W-1:0]        blank_q, blank_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;

    logic [NUM_DIGITS-1:0]   lzb_mask;
    logic [3:0]              cur_digit;
    logic                    cur_dp;
    logic                    cur_blank;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0:    dec7 = 7'b1000000;
            4'd1:    dec7 = 7'b1111001;
            4'd2:    dec7 = 7'b0100100;
            4'd3:    dec7 = 7'b0110000;
            4'd4:    dec7 = 7'b0011001;
            4'd5:    dec7 = 7'b0010010;
            4'd6:    dec7 = 7'b0000010;
            4'd7:    dec7 = 7'b1111000;
            4'd8:    dec7 = 7'b0000000;
            4'd9:    dec7 = 7'b0010000;
            default: dec7 = SEG_OFF;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        dpm_d    = dpm_q;
        ovf_d    = ovf_q;
        digit_d  = digit_q;
        dp_sh_d  = dp_sh_q;
        ovf_sh_d = ovf_sh_q;
        case (state_q)
            S_IDLE: begin
                if (value_valid) begin
                    bin_d   = value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    dpm_d   = dp_mask;
                    ovf_d   = (32'(value) >= OVF_LIMIT);
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (bcd_q[4*i +: 4] >= 4'd5) begin
                        bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
                    end
                end
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                {bcd_d, bin_d} = {bcd_q, bin_q} << 1;
                cnt_d          = cnt_q + 1'b1;
                state_d        = (cnt_q == CNT_W'(BIN_W - 1)) ? S_DONE : S_ADD;
            end
            S_DONE: begin
                digit_d  = bcd_q;
                dp_sh_d  = dpm_q;
                ovf_sh_d = ovf_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
    end

`ifdef SEG7_LZB_EN
    // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
    logic [NUM_DIGITS-1:0] lead_zero;
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
        if (gi == 0) begin : g_lsd
            assign lead_zero[gi] = 1'b0;
        end else begin : g_upper
            assign lead_zero[gi] = (digit_q[BCD_W-1:4*gi] == '0);
        end
    end
    assign lzb_mask = ovf_sh_q ? '0 : lead_zero;
`else
    assign lzb_mask = '0;
`endif

    always_comb begin
        cur_digit = 4'd0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_q == 2'(i)) begin
                cur_digit = digit_q[4*i +: 4];
                cur_dp    = dp_sh_q[i];
                cur_blank = lzb_mask[i];
            end
        end
    end

    always_comb begin
        sel_d   = sel_q;
        blank_d = blank_q;
        an_d    = an_q;
        seg_d   = seg_q;
        dp_d    = dp_q;
        if (sel != sel_q) begin
            sel_d   = sel;
            blank_d = BLK_W'(BLANK_CYC);
            an_d    = '1;
            seg_d   = SEG_OFF;
            dp_d    = 1'b1;
        end else if (blank_q != '0) begin
            blank_d = blank_q - 1'b1;
            an_d    = '1;
            seg_d   = SEG_OFF;
            dp_d    = 1'b1;
        end else if (32'(sel_q) < NUM_DIGITS) begin
            an_d = ~(NUM_DIGITS'(1) << sel_q);
            if (ovf_sh_q) begin
                seg_d = SEG_DASH;
            end else if (cur_blank) begin
                seg_d = SEG_OFF;
            end else begin
                seg_d = dec7(cur_digit);
            end
            dp_d = ~cur_dp;
        end else begin
            an_d  = '1;
            seg_d = SEG_OFF;
            dp_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            dpm_q    <= '0;
            ovf_q    <= 1'b0;
            ready_q  <= 1'b1;
            digit_q  <= '0;
            dp_sh_q  <= '0;
            ovf_sh_q <= 1'b0;
            sel_q    <= 2'd0;
            blank_q  <= '0;
            an_q     <= '1;
            seg_q    <= SEG_OFF;
            dp_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            dpm_q    <= dpm_d;
            ovf_q    <= ovf_d;
            ready_q  <= ready_d;
            digit_q  <= digit_d;
            dp_sh_q  <= dp_sh_d;
            ovf_sh_q <= ovf_sh_d;
            sel_q    <= sel_d;
            blank_q  <= blank_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign value_ready = ready_q;
    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: stimulus queues expected display states and conversion
// latencies; one monitor process pops and compares them.
module tb_seg7_scan_driver;

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] sel;
    logic [9:0] value;
    logic [2:0] dp_mask;
    logic       value_valid;
    logic       value_ready;
    logic [2:0] an;
    logic [6:0] seg;
    logic       dp;

    typedef struct {
        string      name;
        logic [2:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       rdy;
    } exp_t;

    exp_t exp_q[$];
    int   lat_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   final_chk  = 1'b0;
    bit   final_done = 1'b0;
    bit   busy = 1'b0;
    int   low_cnt = 0;

    localparam logic [6:0] S0    = 7'b1000000;
    localparam logic [6:0] S3    = 7'b0110000;
    localparam logic [6:0] S4    = 7'b0011001;
    localparam logic [6:0] S5    = 7'b0010010;
    localparam logic [6:0] S7    = 7'b1111000;
    localparam logic [6:0] SOFF  = 7'h7F;
    localparam logic [6:0] SDASH = 7'b0111111;

    seg7_scan_driver #(.NUM_DIGITS(3), .BIN_W(10), .BLANK_CYC(4)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .sel         (sel),
        .value       (value),
        .dp_mask     (dp_mask),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    always #5 clk = ~clk;

    // Monitor: display checks, conversion latency (measured while ready is low), final drain check.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (an !== e.an || seg !== e.seg || dp !== e.dp || value_ready !== e.rdy) begin
                errors++;
                $display("FAIL %s: got an=%b seg=%b dp=%b rdy=%b want an=%b seg=%b dp=%b rdy=%b",
                         e.name, an, seg, dp, value_ready, e.an, e.seg, e.dp, e.rdy);
            end else begin
                $display("check %s: an=%b seg=%b dp=%b rdy=%b ok", e.name, an, seg, dp, value_ready);
            end
        end
        if (!rstn) begin
            busy    = 1'b0;
            low_cnt = 0;
        end else if (value_ready === 1'b0) begin
            busy = 1'b1;
            low_cnt++;
        end else if (busy) begin
            busy = 1'b0;
            if (lat_q.size() != 0) begin
                int want;
                want = lat_q.pop_front();
                checks++;
                if (low_cnt != want) begin
                    errors++;
                    $display("FAIL busy_cycles: got %0d want %0d", low_cnt, want);
                end else begin
                    $display("check busy_cycles: %0d ok", low_cnt);
                end
            end
            low_cnt = 0;
        end
        if (final_chk && !final_done) begin
            final_done = 1'b1;
            checks++;
            if (lat_q.size() != 0) begin
                errors++;
                $display("FAIL conversions_done: got %0d pending want 0", lat_q.size());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [2:0] a, input logic [6:0] s,
                              input logic d, input logic r);
        exp_t e;
        e.name = name;
        e.an   = a;
        e.seg  = s;
        e.dp   = d;
        e.rdy  = r;
        exp_q.push_back(e);
    endtask

    task automatic convert(input logic [9:0] v, input logic [2:0] m, input bit track);
        int k = 0;
        while (value_ready !== 1'b1 && k < 100) begin
            tick(1);
            k++;
        end
        if (value_ready !== 1'b1) begin
            $display("FAIL ready_timeout: got rdy=%b want 1", value_ready);
            $fatal(1, "value_ready never asserted");
        end
        value       = v;
        dp_mask     = m;
        value_valid = 1'b1;
        if (track) lat_q.push_back(21);
        tick(1);
        value_valid = 1'b0;
    endtask

    initial begin
        rstn        = 1'b0;
        sel         = 2'd0;
        value       = '0;
        dp_mask     = '0;
        value_valid = 1'b0;
        tick(2);
        expect_out("reset", 3'b111, SOFF, 1'b1, 1'b1);
        tick(1);
        rstn = 1'b1;
        sel  = 2'd3;
        tick(10);
        expect_out("sel3_dark", 3'b111, SOFF, 1'b1, 1'b1);
        tick(1);

        // 437 on digit 2 with its decimal point lit
        sel = 2'd2;
        tick(1);
        convert(10'd437, 3'b100, 1'b1);
        tick(22);
        expect_out("v437_d2", 3'b011, S4, 1'b0, 1'b1);
        tick(1);

        sel = 2'd0;
        tick(6);
        expect_out("v437_d0", 3'b110, S7, 1'b1, 1'b1);
        sel = 2'd1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            expect_out($sformatf("blank_%0d", i), 3'b111, SOFF, 1'b1, 1'b1);
        end
        tick(1);
        expect_out("v437_d1", 3'b101, S3, 1'b1, 1'b1);
        tick(1);

        // Overflow: dashes on every digit; commit while lit updates without blanking
        convert(10'd1000, 3'b010, 1'b1);
        tick(22);
        expect_out("ovf_d1", 3'b101, SDASH, 1'b0, 1'b1);
        tick(1);
        sel = 2'd0;
        tick(6);
        expect_out("ovf_d0", 3'b110, SDASH, 1'b1, 1'b1);
        sel = 2'd2;
        tick(6);
        expect_out("ovf_d2", 3'b011, SDASH, 1'b1, 1'b1);
        tick(1);

        // Leading zeros of 7
        convert(10'd7, 3'b000, 1'b1);
        tick(22);
`ifdef SEG7_LZB_EN
        expect_out("v7_d2", 3'b011, SOFF, 1'b1, 1'b1);
`else
        expect_out("v7_d2", 3'b011, S0, 1'b1, 1'b1);
`endif
        tick(1);
        sel = 2'd0;
        tick(6);
        expect_out("v7_d0", 3'b110, S7, 1'b1, 1'b1);
        tick(1);

        // Reset in the middle of a conversion, then a fresh conversion
        convert(10'd123, 3'b111, 1'b0);
        tick(9);
        rstn = 1'b0;
        #1;
        expect_out("mid_reset", 3'b111, SOFF, 1'b1, 1'b1);
        tick(2);
        rstn = 1'b1;
        tick(1);
        expect_out("post_reset_d0", 3'b110, S0, 1'b1, 1'b1);
        tick(1);
        convert(10'd5, 3'b000, 1'b1);
        tick(22);
        expect_out("v5_d0", 3'b110, S5, 1'b1, 1'b1);
        tick(2);

        final_chk = 1'b1;
        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
